pool_bram_ctrl: RTL and testbench
=================================

# pool_bram_ctrl

Frame-level sequencer for the 3x3 absolute-deviation max-pooling kernel in the pooling BRAM path. On `start`, it scans every 3x3 window of an image held in an input BRAM with a synchronous read port. For each window it assembles the 72-bit window word and presents it to the combinational `kernalpoolingmax` instance it owns. It then writes the 8-bit result to an output BRAM in raster order and pulses `done`.

## Interface
- `DWIDTH`, 8, pixel width. The kernel is fixed at 8, so any other value is an elaboration error.
- `IMG_W`, 8, image width in pixels; must be ≥3.
- `IMG_H`, 8, image height in pixels; must be ≥3.
- `STRIDE`, 1, window step in both axes; must be ≥1.
- `AW`, 6, input address width; must satisfy 2^AW ≥ IMG_W*IMG_H.
- `OAW`, 6, output address width; must hold OUT_W*OUT_H.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; sampled only in IDLE.
- `busy` out 1: high from the cycle after an accepted `start` through DONE.
- `done` out 1: one-cycle pulse at frame end.
- `rd_en` out 1: input BRAM read enable.
- `rd_addr` out AW: input BRAM read address.
- `rd_data` in DWIDTH: input BRAM read data, valid 1 cycle after `rd_en`.
- `wr_en` out 1: output BRAM write enable.
- `wr_addr` out OAW: output BRAM write address.
- `wr_data` out DWIDTH: pooled result.

## Operation
- Derived constants: OUT_W = (IMG_W-3)/STRIDE+1, OUT_H = (IMG_H-3)/STRIDE+1, NWIN = OUT_W*OUT_H.
- Window origin is (row, col) = (oy*STRIDE, ox*STRIDE).
- Tap k = 0..8 has r = k/3 and c = k%3. It reads `rd_addr` = (row+r)*IMG_W + (col+c).
- Tap k is stored at `window[k*8 +: 8]`, which is the kernel's packing: row r, column c at bits (r*3+c)*8.
- FSM states and transitions:
  - IDLE: go to FETCH on `start`. Clear oy, ox and k.
  - FETCH: `rd_en`=1 and `rd_addr`=tap k. Stay for k = 0..8, then go to LAST.
  - LAST: no read. Capture tap 8, then go to WRITE.
  - WRITE: `wr_en`=1, `wr_data`=kernel output, `wr_addr`=oy*OUT_W+ox. Advance ox, wrapping ox to 0 and incrementing oy. After window NWIN-1 go to DONE, otherwise to FETCH.
  - DONE: `done`=1, then go to IDLE.
- Tap capture: tap k-1 is captured in FETCH cycle k (k ≥ 1); tap 8 is captured in LAST.
- The window register is not cleared between windows; every byte is overwritten before WRITE.
- `start` is ignored in every state except IDLE, including a `start` that coincides with DONE.
- Reset mid-frame aborts the frame. The FSM returns to IDLE; the output BRAM contents are whatever was written so far.
- Address arithmetic is unsigned and computed at full width before truncation to AW/OAW.

## Timing
- Reset values: `busy`, `done`, `rd_en` and `wr_en` are 0. `rd_addr`, `wr_addr`, `wr_data` and the window register are 0. State is IDLE.
- All outputs are registered.
- Per window: 9 FETCH + 1 LAST + 1 WRITE = 11 cycles.
- `start` at cycle 0:
  - first `rd_en` at cycle 1;
  - first `wr_en` at cycle 11;
  - last `wr_en` at cycle 11*NWIN;
  - `done` at cycle 11*NWIN+1;
  - `busy` falls at cycle 11*NWIN+2;
  - a new `start` is accepted from cycle 11*NWIN+2.
- `rd_en` and `wr_en` are never high in the same cycle.

## Configuration
- `POOL_CTRL_PEAK_EN` defined: adds output port `peak` (DWIDTH) holding the largest `wr_data` written this frame.
  - Cleared to 0 on accepted `start` and on reset.
  - Updated in the cycle after each WRITE.
  - Holds its value after `done`.
- Not defined: no `peak` port and no peak logic.

## Structure
- Shared package `pool_ctrl_pkg` holds:
  - the state encoding IDLE/FETCH/LAST/WRITE/DONE;
  - the tap count 9;
  - the window width 72;
  - the OUT_W/OUT_H derivation helpers.
- Sub-module `pool_win_addr_gen`: the oy/ox/k counters, producing `rd_addr`, `wr_addr` and the last-tap/last-window flags.
- `kernalpoolingmax` is instantiated directly on the window register.

## Test plan
- 5x5 image, all pixels 0x40, stride 1 → 9 writes, all data 0x00, addresses 0..8; `done` at cycle 100.
- 5x5 ramp, pixel = address → every write 0x01; `rd_addr` for window 0 is 0,1,2,5,6,7,10,11,12.
- 6x6 image, stride 3, window 3 at (3,3) with one row 0x00,0xFF,0x00 → `wr_addr` 3 carries 0xFF; total of 4 writes.
- `start` pulsed during FETCH and again in DONE → ignored, no second frame; `start` two cycles after `done` → new frame runs.
- `rst_n` low mid-FETCH of window 4 → all outputs 0 asynchronously; next `start` rescans from window 0.
- `POOL_CTRL_PEAK_EN` build, results 3,9,2 → `peak` = 9 after `done`; a new `start` clears it to 0.

Source files
------------

// File: rtl/pool_ctrl_pkg.sv
// Shared state encoding, window geometry constants and output-size helpers
// for the pooling BRAM sequencer (pool_bram_ctrl and its address generator).
package pool_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LAST  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned NTAPS = 9;
  localparam int unsigned WIN_W = 72;

  function automatic int unsigned out_dim(input int unsigned img, input int unsigned stride);
    return (img - 3) / stride + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/kernalpoolingmax.sv
// Combinational 3x3 absolute-deviation max kernel: the largest |a-b| over the
// horizontally adjacent pixel pairs of each window row (8-bit pixels).
module kernalpoolingmax (
  input  logic [71:0] window_i,
  output logic [7:0]  result_o
);

  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] d;

  always_comb begin
    result_o = '0;
    a        = '0;
    b        = '0;
    d        = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        a = window_i[(r*3 + c)*8 +: 8];
        b = window_i[(r*3 + c + 1)*8 +: 8];
        d = (a > b) ? (a - b) : (b - a);
        if (d > result_o) result_o = d;
      end
    end
  end

endmodule

// File: rtl/pool_win_addr_gen.sv
// Window/tap counters for the pooling sequencer: produces the registered input
// read address, output write address and the last-tap / last-window flags.
module pool_win_addr_gen
  import pool_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned AW     = 6,
  parameter int unsigned OAW    = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear_i,
  input  logic           tap_adv_i,
  input  logic           win_adv_i,
  output logic [AW-1:0]  rd_addr_o,
  output logic [OAW-1:0] wr_addr_o,
  output logic           first_tap_o,
  output logic           last_tap_o,
  output logic           last_win_o
);

  localparam int unsigned OUT_W = out_dim(IMG_W, STRIDE);
  localparam int unsigned OUT_H = out_dim(IMG_H, STRIDE);
  localparam int unsigned XW    = cnt_width(OUT_W);
  localparam int unsigned YW    = cnt_width(OUT_H);
  localparam logic [XW-1:0] OX_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] OY_LAST = YW'(OUT_H - 1);
  localparam logic [3:0]    K_LAST  = 4'(NTAPS - 1);

  logic [XW-1:0]  ox_q, ox_d;
  logic [YW-1:0]  oy_q, oy_d;
  logic [3:0]     k_q, k_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic [OAW-1:0] wr_addr_q, wr_addr_d;

  // NOTE: every next-state variable takes its hold value first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    ox_d = ox_q;
    oy_d = oy_q;
    k_d  = k_q;
    if (clear_i) begin
      ox_d = '0;
      oy_d = '0;
      k_d  = '0;
    end else if (win_adv_i) begin
      k_d = '0;
      if (ox_q == OX_LAST) begin
        ox_d = '0;
        oy_d = (oy_q == OY_LAST) ? '0 : oy_q + 1'b1;
      end else begin
        ox_d = ox_q + 1'b1;
      end
    end else if (tap_adv_i && (k_q != K_LAST)) begin
      k_d = k_q + 4'd1;
    end
  end

  // Addresses come from the next counter values so the registered ports line
  // up with the cycle whose counters they describe.
  always_comb begin
    rd_addr_d = AW'((32'(oy_d) * STRIDE + 32'(k_d) / 3) * IMG_W
                    + 32'(ox_d) * STRIDE + 32'(k_d) % 3);
    wr_addr_d = OAW'(32'(oy_d) * OUT_W + 32'(ox_d));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox_q      <= '0;
      oy_q      <= '0;
      k_q       <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      k_q       <= k_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign rd_addr_o   = rd_addr_q;
  assign wr_addr_o   = wr_addr_q;
  assign first_tap_o = (k_q == '0);
  assign last_tap_o  = (k_q == K_LAST);
  assign last_win_o  = (ox_q == OX_LAST) && (oy_q == OY_LAST);

endmodule

// File: rtl/pool_bram_ctrl.sv
// Frame sequencer: scans every 3x3 window from the input BRAM, pools it and
// writes results in raster order. Optional `peak` port via POOL_CTRL_PEAK_EN.
module pool_bram_ctrl
  import pool_ctrl_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned AW     = 6,
  parameter int unsigned OAW    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DWIDTH-1:0] rd_data,
  output logic              wr_en,
  output logic [OAW-1:0]    wr_addr,
  output logic [DWIDTH-1:0] wr_data
`ifdef POOL_CTRL_PEAK_EN
  ,
  output logic [DWIDTH-1:0] peak
`endif
);

  localparam int unsigned OUT_W = out_dim(IMG_W, STRIDE);
  localparam int unsigned OUT_H = out_dim(IMG_H, STRIDE);
  localparam int unsigned NWIN  = OUT_W * OUT_H;

  if (DWIDTH != 8) begin : g_bad_dwidth
    $error("pool_bram_ctrl: DWIDTH must be 8 to match the pooling kernel");
  end
  if ((IMG_W < 3) || (IMG_H < 3) || (STRIDE == 0)) begin : g_bad_geom
    $error("pool_bram_ctrl: image must be at least 3x3 and STRIDE at least 1");
  end
  if ((2**AW < IMG_W * IMG_H) || (2**OAW < NWIN)) begin : g_bad_aw
    $error("pool_bram_ctrl: AW/OAW too narrow for the image or output frame");
  end

  state_e state_q, state_d;
  logic   start_ok;
  logic   first_tap, last_tap, last_win;
  logic   busy_q, done_q, rd_en_q, wr_en_q;
  logic   capture;
  logic [WIN_W-1:0] window_q;
  logic [7:0]       kern_res;

  assign start_ok = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: if (last_tap) state_d = ST_LAST;
      ST_LAST:  state_d = ST_WRITE;
      ST_WRITE: state_d = last_win ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  pool_win_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .STRIDE(STRIDE),
    .AW    (AW),
    .OAW   (OAW)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start_ok),
    .tap_adv_i  (state_q == ST_FETCH),
    .win_adv_i  (state_q == ST_WRITE),
    .rd_addr_o  (rd_addr),
    .wr_addr_o  (wr_addr),
    .first_tap_o(first_tap),
    .last_tap_o (last_tap),
    .last_win_o (last_win)
  );

  // Read data lags its address by one cycle: tap k-1 lands while tap k is
  // requested, and tap 8 lands in LAST. Shifting in from the top leaves tap 0
  // at bits [7:0] after nine captures.
  assign capture = ((state_q == ST_FETCH) && !first_tap) || (state_q == ST_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      // NOTE: the window is a plain register bank rather than a RAM, so it is
      // reset with the control state and the pooled output starts at 0.
      window_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      rd_en_q <= (state_d == ST_FETCH);
      wr_en_q <= (state_d == ST_WRITE);
      if (capture) window_q <= {rd_data, window_q[WIN_W-1:DWIDTH]};
    end
  end

  kernalpoolingmax u_kernel (
    .window_i(window_q),
    .result_o(kern_res)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign wr_en   = wr_en_q;
  assign wr_data = kern_res;

`ifdef POOL_CTRL_PEAK_EN
  logic [DWIDTH-1:0] peak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else if (start_ok) begin
      peak_q <= '0;
    end else if ((state_q == ST_WRITE) && (kern_res > peak_q)) begin
      peak_q <= kern_res;
    end
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_pool_bram_ctrl.sv
// Self-checking bench for pool_bram_ctrl: a 5x5/stride-1 and a 6x6/stride-3
// instance, each fed from a behavioural input BRAM and checked against a model.
module tb_pool_bram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  int   cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_start = 1'b0, a_busy, a_done, a_rd_en, a_wr_en;
  logic [4:0] a_rd_addr;
  logic [7:0] a_rd_data = '0, a_wr_data;
  logic [3:0] a_wr_addr;
  logic       b_start = 1'b0, b_busy, b_done, b_rd_en, b_wr_en;
  logic [5:0] b_rd_addr;
  logic [7:0] b_rd_data = '0, b_wr_data;
  logic [1:0] b_wr_addr;
`ifdef POOL_CTRL_PEAK_EN
  logic [7:0] a_peak, b_peak;
`endif

  pool_bram_ctrl #(.DWIDTH(8), .IMG_W(5), .IMG_H(5), .STRIDE(1), .AW(5), .OAW(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
`ifdef POOL_CTRL_PEAK_EN
    , .peak(a_peak)
`endif
  );

  pool_bram_ctrl #(.DWIDTH(8), .IMG_W(6), .IMG_H(6), .STRIDE(3), .AW(6), .OAW(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
`ifdef POOL_CTRL_PEAK_EN
    , .peak(b_peak)
`endif
  );

  // Image memories and geometry, indexed by instance (0 = 5x5/s1, 1 = 6x6/s3).
  logic [7:0] img [2][64];
  int gw [2] = '{5, 6};
  int gs [2] = '{1, 3};

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= img[0][a_rd_addr];
    if (b_rd_en) b_rd_data <= img[1][b_rd_addr];
  end

  typedef struct {
    int addr;
    int data;
    int cyc;
  } ev_t;

  ev_t  wq [2][$];
  ev_t  rq [2][$];
  int   dq [2][$];
  int   fq [2][$];
  int   overlap [2];
  logic pbusy [2];

  always @(negedge clk) begin
    if (a_rd_en) rq[0].push_back('{int'(a_rd_addr), 0, cyc});
    if (a_wr_en) wq[0].push_back('{int'(a_wr_addr), int'(a_wr_data), cyc});
    if (a_done) dq[0].push_back(cyc);
    if (a_rd_en && a_wr_en) overlap[0]++;
    if (pbusy[0] === 1'b1 && a_busy === 1'b0) fq[0].push_back(cyc);
    pbusy[0] = a_busy;
    if (b_rd_en) rq[1].push_back('{int'(b_rd_addr), 0, cyc});
    if (b_wr_en) wq[1].push_back('{int'(b_wr_addr), int'(b_wr_data), cyc});
    if (b_done) dq[1].push_back(cyc);
    if (b_rd_en && b_wr_en) overlap[1]++;
    if (pbusy[1] === 1'b1 && b_busy === 1'b0) fq[1].push_back(cyc);
    pbusy[1] = b_busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int out_w(input int inst);
    return (gw[inst] - 3) / gs[inst] + 1;
  endfunction

  function automatic int nwin(input int inst);
    return out_w(inst) * out_w(inst);
  endfunction

  // Largest absolute difference between horizontal neighbours in the window.
  function automatic int model_win(input int inst, input int i);
    int row0 = (i / out_w(inst)) * gs[inst];
    int col0 = (i % out_w(inst)) * gs[inst];
    int best = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        int p = int'(img[inst][(row0 + r) * gw[inst] + col0 + c]);
        int q = int'(img[inst][(row0 + r) * gw[inst] + col0 + c + 1]);
        int d = (p > q) ? p - q : q - p;
        if (d > best) best = d;
      end
    end
    return best;
  endfunction

  function automatic int model_peak(input int inst);
    int m = 0;
    for (int i = 0; i < nwin(inst); i++)
      if (model_win(inst, i) > m) m = model_win(inst, i);
    return m;
  endfunction

  function automatic int exp_rd(input int inst, input int j);
    int i = j / 9;
    int k = j % 9;
    return ((i / out_w(inst)) * gs[inst] + k / 3) * gw[inst]
           + (i % out_w(inst)) * gs[inst] + k % 3;
  endfunction

`ifdef POOL_CTRL_PEAK_EN
  function automatic int get_peak(input int inst);
    return (inst == 0) ? int'(a_peak) : int'(b_peak);
  endfunction
`endif

  // ---------------- stimulus helpers ----------------
  task automatic clear_mon(input int inst);
    wq[inst].delete();
    rq[inst].delete();
    dq[inst].delete();
    fq[inst].delete();
    overlap[inst] = 0;
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) a_start = v;
    else           b_start = v;
  endtask

  task automatic wait_done(input int inst, input int count);
    int n = 0;
    while (dq[inst].size() < count && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (dq[inst].size() < count) check("done_timeout", dq[inst].size(), count);
  endtask

  task automatic run_frame(input int inst, output int t0);
    clear_mon(inst);
    @(negedge clk);
    set_start(inst, 1'b1);
    t0 = cyc;
    @(negedge clk);
    set_start(inst, 1'b0);
    wait_done(inst, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input int inst, input int t0, input string tag);
    int n = nwin(inst);
    check({tag, "_wr_count"}, wq[inst].size(), n);
    for (int i = 0; i < n && i < wq[inst].size(); i++) begin
      check({tag, "_wr_addr"}, wq[inst][i].addr, i);
      check({tag, "_wr_data"}, wq[inst][i].data, model_win(inst, i));
      check({tag, "_wr_cycle"}, wq[inst][i].cyc - t0, 11 * (i + 1));
    end
    check({tag, "_rd_count"}, rq[inst].size(), 9 * n);
    for (int j = 0; j < 9 * n && j < rq[inst].size(); j++)
      check({tag, "_rd_addr"}, rq[inst][j].addr, exp_rd(inst, j));
    check({tag, "_first_rd_cycle"}, (rq[inst].size() > 0) ? rq[inst][0].cyc - t0 : -1, 1);
    check({tag, "_done_count"}, dq[inst].size(), 1);
    check({tag, "_done_cycle"}, (dq[inst].size() > 0) ? dq[inst][0] - t0 : -1, 11 * n + 1);
    check({tag, "_busy_fall"}, (fq[inst].size() > 0) ? fq[inst][0] - t0 : -1, 11 * n + 2);
    check({tag, "_rd_wr_overlap"}, overlap[inst], 0);
`ifdef POOL_CTRL_PEAK_EN
    check({tag, "_peak"}, get_peak(inst), model_peak(inst));
`endif
  endtask

  task automatic fill_pattern(input int pat);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        case (pat)
          0:       img[0][r*5 + c] = 8'h40;
          1:       img[0][r*5 + c] = 8'(r*5 + c);
          2:       img[0][r*5 + c] = (c % 2 == 1) ? 8'h80 : 8'h00;
          3:       img[0][r*5 + c] = 8'(r * 32);
          default: img[0][r*5 + c] = (c == 2) ? 8'hFF : 8'h10;
        endcase
      end
    end
  endtask

  typedef struct {
    string      name;
    int         pat;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [5];
  int   ramp_rd [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int   s3_exp [4]  = '{0, 0, 0, 255};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
    $fatal(1);
  end

  initial begin
    int t0, t1, d;
    bit seen;

    vecs[0] = '{"flat40",  0, 8'h00};
    vecs[1] = '{"ramp",    1, 8'h01};
    vecs[2] = '{"colstrp", 2, 8'h80};
    vecs[3] = '{"rowgrad", 3, 8'h00};
    vecs[4] = '{"spike",   4, 8'hEF};
    for (int i = 0; i < 64; i++) begin
      img[0][i] = '0;
      img[1][i] = '0;
    end

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_a_outputs", {a_busy, a_done, a_rd_en, a_wr_en, a_rd_addr, a_wr_addr, a_wr_data}, 0);
    check("rst_b_outputs", {b_busy, b_done, b_rd_en, b_wr_en, b_rd_addr, b_wr_addr, b_wr_data}, 0);
`ifdef POOL_CTRL_PEAK_EN
    check("rst_peak", {a_peak, b_peak}, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven patterns on the 5x5 instance
    for (int v = 0; v < 5; v++) begin
      fill_pattern(vecs[v].pat);
      run_frame(0, t0);
      check_frame(0, t0, vecs[v].name);
      for (int i = 0; i < wq[0].size(); i++)
        check({"tbl_", vecs[v].name}, wq[0][i].data, vecs[v].exp);
      check({"tbl_done100_", vecs[v].name}, (dq[0].size() > 0) ? dq[0][0] - t0 : -1, 100);
      if (vecs[v].pat == 1)
        for (int j = 0; j < 9 && j < rq[0].size(); j++)
          check("ramp_win0_rd_addr", rq[0][j].addr, ramp_rd[j]);
    end

    // Stride 3: spike row inside window 3
    img[1][21] = 8'h00;
    img[1][22] = 8'hFF;
    img[1][23] = 8'h00;
    run_frame(1, t0);
    check_frame(1, t0, "s3");
    check("s3_writes", wq[1].size(), 4);
    for (int i = 0; i < 4 && i < wq[1].size(); i++)
      check("s3_tbl_data", wq[1][i].data, s3_exp[i]);

    // start during FETCH and in DONE ignored; start two cycles after done accepted
    fill_pattern(1);
    clear_mon(0);
    @(negedge clk);
    a_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    a_start = 1'b0;
    repeat (2) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    seen = 1'b0;
    d = -1;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (a_done) begin
        seen = 1'b1;
        d = cyc;
      end
    end
    check("ign_done_seen", seen, 1);
    check("ign_done_cycle", d - t0, 100);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    a_start = 1'b1;
    t1 = cyc;
    @(negedge clk);
    a_start = 1'b0;
    wait_done(0, 2);
    repeat (3) @(negedge clk);
    check("restart_done_count", dq[0].size(), 2);
    check("restart_wr_count", wq[0].size(), 18);
    check("restart_rd_count", rq[0].size(), 162);
    check("restart_first_rd", (rq[0].size() > 81) ? rq[0][81].cyc - t1 : -1, 1);
    check("restart_done_cycle", (dq[0].size() > 1) ? dq[0][1] - t1 : -1, 100);
    check("restart_win0_addr", (wq[0].size() > 9) ? wq[0][9].addr : -1, 0);

    // Reset in the middle of window 4's FETCH
    for (int i = 0; i < 25; i++) img[0][i] = 8'($urandom_range(0, 255));
    clear_mon(0);
    @(negedge clk);
    a_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    a_start = 1'b0;
    while (cyc < t0 + 48) @(negedge clk);
    check("midrst_pre_rd_en", a_rd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {a_busy, a_done, a_rd_en, a_wr_en, a_rd_addr, a_wr_addr, a_wr_data}, 0);
    check("midrst_partial_writes", wq[0].size(), 4);
`ifdef POOL_CTRL_PEAK_EN
    check("midrst_peak", a_peak, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(0, t0);
    check_frame(0, t0, "after_rst");

    // Randomized frames on both instances
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 25; i++) img[0][i] = 8'($urandom_range(0, 255));
      run_frame(0, t0);
      check_frame(0, t0, "rand5");
    end
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 36; i++) img[1][i] = 8'($urandom_range(0, (f == 0) ? 15 : 255));
      run_frame(1, t0);
      check_frame(1, t0, "rand6");
    end

`ifdef POOL_CTRL_PEAK_EN
    // Window results 3, 9, 2, 0 -> peak 9, then cleared by the next start
    for (int i = 0; i < 36; i++) img[1][i] = '0;
    img[1][1]  = 8'd3;
    img[1][4]  = 8'd9;
    img[1][19] = 8'd2;
    run_frame(1, t0);
    check("peak_after_done", b_peak, 9);
    clear_mon(1);
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    #1;
    check("peak_cleared_on_start", b_peak, 0);
    wait_done(1, 1);
    repeat (3) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
